// File: rtl/keccak_round_ctrl_if.sv
// rtl/keccak_round_ctrl_if.sv - handshake and round-control bundle for the Keccak round sequencer
//
// Purpose: groups the signals exchanged between the round sequencer
// (master) and the surrounding sponge logic / round datapath (slave).
// Signals:
//   in_valid   new state present at datapath input
//   in_ready   sequencer accepts a state this cycle
//   load_en    datapath captures the input state this cycle
//   round_en   datapath applies the round group this cycle
//   round      first round index applied this cycle (RC ROM address)
//   round_last round_en and this is the final round group
//   out_valid  permutation result stable at datapath output
//   out_ready  consumer takes the result this cycle
//   busy       sequencer not idle
interface keccak_round_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic       load_en;
  logic       round_en;
  logic [4:0] round;
  logic       round_last;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  modport master (
    input  in_valid, out_ready,
    output in_ready, load_en, round_en, round, round_last, out_valid, busy
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, load_en, round_en, round, round_last, out_valid, busy
  );
endinterface

// File: rtl/keccak_round_ctrl.sv
// rtl/keccak_round_ctrl.sv - round sequencer for the iterative Keccak-p permutation
//
// Purpose: accepts one state per in_valid/in_ready handshake, pulses load_en,
// steps the round index through 24-NUM_ROUNDS .. 23 in groups of UNROLL,
// then holds the result under out_valid/out_ready.
// Ports:
//   clk     rising-edge system clock
//   resetn  synchronous active-low reset
//   bus     keccak_round_ctrl_if.master (handshakes, load/round strobes, busy)
module keccak_round_ctrl #(
  parameter int NUM_ROUNDS = 24,
  parameter int UNROLL     = 1
) (
  input logic                 clk,
  input logic                 resetn,
  keccak_round_ctrl_if.master bus
);

  generate
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 24 || UNROLL < 1 || (NUM_ROUNDS % UNROLL) != 0) begin : g_bad_params
      $error("keccak_round_ctrl: NUM_ROUNDS must be 1..24 and a multiple of UNROLL");
    end
  endgenerate

  localparam logic [4:0] FIRST_ROUND = 5'(24 - NUM_ROUNDS);
  localparam logic [4:0] LAST_ROUND  = 5'(24 - UNROLL);
  localparam logic [4:0] ROUND_STEP  = 5'(UNROLL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PERM = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     state;
  logic [4:0] round_q;
  logic       round_en_q;
  logic       round_last_q;
  logic       out_valid_q;
  logic       busy_q;
  logic       accept;

  // A finished result can be swapped for a new state in the same cycle,
  // so HOLD with out_ready is as ready as IDLE.
  assign bus.in_ready = (state == IDLE) || ((state == HOLD) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.load_en  = accept;

  assign bus.round      = round_q;
  assign bus.round_en   = round_en_q;
  assign bus.round_last = round_last_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;

  // round_q doubles as the round counter: it is only non-zero in PERM, and
  // it is cleared on the way out so the RC ROM address reads 0 when idle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      round_q      <= 5'd0;
      round_en_q   <= 1'b0;
      round_last_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else if (accept) begin
      state        <= PERM;
      round_q      <= FIRST_ROUND;
      round_en_q   <= 1'b1;
      round_last_q <= (FIRST_ROUND == LAST_ROUND);
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      case (state)
        PERM: begin
          if (round_q == LAST_ROUND) begin
            state        <= HOLD;
            round_q      <= 5'd0;
            round_en_q   <= 1'b0;
            round_last_q <= 1'b0;
            out_valid_q  <= 1'b1;
          end else begin
            round_q      <= round_q + ROUND_STEP;
            round_last_q <= ((round_q + ROUND_STEP) == LAST_ROUND);
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// tb/tb_keccak_round_ctrl.sv - self-checking bench for keccak_round_ctrl in three configurations
module tb_keccak_round_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  keccak_round_ctrl_if if0 ();
  keccak_round_ctrl_if if1 ();
  keccak_round_ctrl_if if2 ();

  assign if0.in_valid  = in_valid;
  assign if1.in_valid  = in_valid;
  assign if2.in_valid  = in_valid;
  assign if0.out_ready = out_ready;
  assign if1.out_ready = out_ready;
  assign if2.out_ready = out_ready;

  keccak_round_ctrl #(.NUM_ROUNDS(24), .UNROLL(1)) u0 (.clk(clk), .resetn(resetn), .bus(if0.master));
  keccak_round_ctrl #(.NUM_ROUNDS(24), .UNROLL(2)) u1 (.clk(clk), .resetn(resetn), .bus(if1.master));
  keccak_round_ctrl #(.NUM_ROUNDS(12), .UNROLL(1)) u2 (.clk(clk), .resetn(resetn), .bus(if2.master));

  logic [2:0] d_in_ready, d_load_en, d_round_en, d_last, d_out_valid, d_busy;
  logic [4:0] d_round [3];

  assign d_in_ready  = {if2.in_ready,   if1.in_ready,   if0.in_ready};
  assign d_load_en   = {if2.load_en,    if1.load_en,    if0.load_en};
  assign d_round_en  = {if2.round_en,   if1.round_en,   if0.round_en};
  assign d_last      = {if2.round_last, if1.round_last, if0.round_last};
  assign d_out_valid = {if2.out_valid,  if1.out_valid,  if0.out_valid};
  assign d_busy      = {if2.busy,       if1.busy,       if0.busy};
  assign d_round[0]  = if0.round;
  assign d_round[1]  = if1.round;
  assign d_round[2]  = if2.round;

  function automatic int nr_of(input int c);
    return (c == 2) ? 12 : 24;
  endfunction

  function automatic int un_of(input int c);
    return (c == 1) ? 2 : 1;
  endfunction

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 50)
        $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, c, cyc, act, exp);
    end
  endtask

  // Reference model: phase 0 = idle, 1 = permuting (step = round groups done),
  // 2 = holding result. Expected round index follows from the step arithmetic.
  int m_mode [3];
  int m_step [3];

  initial begin
    for (int c = 0; c < 3; c++) begin
      m_mode[c] = 0;
      m_step[c] = 0;
    end
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int c = 0; c < 3; c++) begin
          int groups, e_ir, e_ld, e_re, e_rd, e_last, e_ov, e_busy;
          groups = nr_of(c) / un_of(c);
          e_ir = 0; e_re = 0; e_rd = 0; e_last = 0; e_ov = 0; e_busy = 0;
          if (m_mode[c] == 0) begin
            e_ir = 1;
          end else if (m_mode[c] == 1) begin
            e_re   = 1;
            e_rd   = 24 - nr_of(c) + un_of(c) * m_step[c];
            e_last = (m_step[c] == groups - 1) ? 1 : 0;
            e_busy = 1;
          end else begin
            e_ov   = 1;
            e_ir   = out_ready ? 1 : 0;
            e_busy = 1;
          end
          e_ld = (e_ir != 0 && in_valid) ? 1 : 0;

          check("in_ready",   c, 32'(d_in_ready[c]),  32'(e_ir));
          check("load_en",    c, 32'(d_load_en[c]),   32'(e_ld));
          check("round_en",   c, 32'(d_round_en[c]),  32'(e_re));
          check("round",      c, 32'(d_round[c]),     32'(e_rd));
          check("round_last", c, 32'(d_last[c]),      32'(e_last));
          check("out_valid",  c, 32'(d_out_valid[c]), 32'(e_ov));
          check("busy",       c, 32'(d_busy[c]),      32'(e_busy));

          if (!resetn) begin
            m_mode[c] = 0;
          end else if (e_ld != 0) begin
            m_mode[c] = 1;
            m_step[c] = 0;
          end else if (m_mode[c] == 1) begin
            if (m_step[c] == groups - 1) m_mode[c] = 2;
            else m_step[c] = m_step[c] + 1;
          end else if (m_mode[c] == 2 && out_ready) begin
            m_mode[c] = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    int ov_at [3];
    int n_ld [3];
    bit found;

    // Reset state
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_in_ready", 0, 32'(if0.in_ready), 32'd1);
    check("rst_busy",     0, 32'(if0.busy),     32'd0);
    check("rst_round",    0, 32'(if0.round),    32'd0);
    check("rst_out_valid",0, 32'(if0.out_valid),32'd0);
    resetn = 1'b1;
    tick();

    // Single accept, then hold the result with out_ready low
    in_valid = 1'b1;
    t0 = cyc;
    for (int c = 0; c < 3; c++) ov_at[c] = -1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++)
        if (ov_at[c] < 0 && d_out_valid[c]) ov_at[c] = cyc;
      if (cyc == t0 + 1) begin
        check("first_round_u1", 0, 32'(if0.round), 32'd0);
        check("first_round_n12", 2, 32'(if2.round), 32'd12);
      end
      if (cyc == t0 + 24) begin
        check("last_round", 0, 32'(if0.round), 32'd23);
        check("last_flag",  0, 32'(if0.round_last), 32'd1);
      end
    end
    check("latency_24x1", 0, 32'(ov_at[0] - t0), 32'd25);
    check("latency_24x2", 1, 32'(ov_at[1] - t0), 32'd13);
    check("latency_12x1", 2, 32'(ov_at[2] - t0), 32'd13);
    check("held_out_valid", 0, 32'(if0.out_valid), 32'd1);
    tick();
    out_ready = 1'b1;
    tick();
    check("idle_after_take", 0, 32'(if0.busy), 32'd0);

    // in_valid and out_ready tied high: back-to-back permutations
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) n_ld[c] = 0;
    for (int i = 0; i < 75; i++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) if (d_load_en[c]) n_ld[c]++;
    end
    check("b2b_accepts", 0, 32'(n_ld[0]), 32'd3);
    check("b2b_accepts", 1, 32'(n_ld[1]), 32'd6);
    check("b2b_accepts", 2, 32'(n_ld[2]), 32'd6);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 30; i++) tick();

    // Reset in the middle of a permutation
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (if0.round == 5'd10) found = 1'b1;
    end
    check("find_round10", 0, 32'(found), 32'd1);
    resetn = 1'b0;
    tick();
    check("midrst_busy",  0, 32'(if0.busy),      32'd0);
    check("midrst_round", 0, 32'(if0.round),     32'd0);
    check("midrst_ov",    0, 32'(if0.out_valid), 32'd0);
    resetn = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("restart_round",    0, 32'(if0.round),    32'd0);
    check("restart_round_en", 0, 32'(if0.round_en), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) tick();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      resetn    = ($urandom % 150) != 0;
      in_valid  = ($urandom % 3) != 0;
      out_ready = ($urandom % 2) != 0;
      tick();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
